icache_fetch_responder: RTL and testbench

Direct-mapped instruction cache on the responder side of the instruction-fetch interface. It takes the fetch stage's PC and returns a 16-bit instruction word, along with a ready flag that the datapath uses as the fetch enable. On a miss it stalls fetch and refills a full line from the off-chip instruction memory through a req/ack handshake. It sits between the IF stage and the DE2 off-chip memory controller, replacing the combinational instruction ROM.

---
 rtl/icache_fetch_responder_pkg.sv | 19 +
 rtl/icache_tag_store.sv | 37 +++
 rtl/icache_fetch_responder.sv | 134 +++++++++++++
 tb/tb_icache_fetch_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_responder_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
// Tag width is derived from the address split: tag | index | word offset.
package icache_fetch_responder_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;
  localparam int OFS_W  = 2;
  localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
  localparam int LINES  = 1 << IDX_W;
  localparam int WORDS  = 1 << (IDX_W + OFS_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_tag_store.sv
// Tag and valid arrays for the instruction cache: asynchronous lookup compare,
// single-line fill and bulk invalidate. Tags are not reset; valid bits are.
module icache_tag_store
  import icache_fetch_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_inval,
  output logic             o_match
);

  logic [TAG_W-1:0] r_tag_mem [LINES];
  logic [LINES-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_tag_mem[i_wr_idx] <= i_wr_tag;
  end

  // Invalidate wins over a fill; the FSM never requests both in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_inval) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  assign o_match = r_valid[i_rd_idx] && (r_tag_mem[i_rd_idx] == i_rd_tag);

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped I-cache answering the fetch stage with zero-latency hits and
// refilling whole lines over a req/ack port. Define ICACHE_STATS_EN for hit/miss counters.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  state_t            r_state;
  logic [TAG_W-1:0]  r_miss_tag;
  logic [IDX_W-1:0]  r_miss_idx;
  logic [OFS_W-1:0]  r_word_cnt;
  logic              r_flush_pend;
  logic              r_mem_rd_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_data [WORDS];

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFS_W-1:0]  w_ofs;
  logic              w_match;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_ack;
  logic              w_fill_last;
  logic              w_inval;

  assign w_tag = fetch_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = fetch_addr[OFS_W +: IDX_W];
  assign w_ofs = fetch_addr[OFS_W-1:0];

  // A flush cycle in IDLE neither hits nor starts a refill; the next lookup misses.
  assign w_hit       = (r_state == IDLE) && w_match && !flush;
  assign w_miss      = (r_state == IDLE) && !w_match && !flush;
  assign w_fill_ack  = (r_state == REFILL) && mem_ack;
  assign w_fill_last = w_fill_ack && (r_word_cnt == '1);
  assign w_inval     = ((r_state == IDLE) && flush) ||
                       ((r_state == DONE) && (flush || r_flush_pend));

  icache_tag_store u_tag_store (
    .clk      (clk),
    .rst      (rst),
    .i_rd_idx (w_idx),
    .i_rd_tag (w_tag),
    .i_wr_en  (w_fill_last),
    .i_wr_idx (r_miss_idx),
    .i_wr_tag (r_miss_tag),
    .i_inval  (w_inval),
    .o_match  (w_match)
  );

  always_ff @(posedge clk) begin
    if (w_fill_ack) r_data[{r_miss_idx, r_word_cnt}] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_mem_rd_req <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_tag   <= w_tag;
            r_miss_idx   <= w_idx;
            r_word_cnt   <= '0;
            r_mem_rd_req <= 1'b1;
            r_mem_addr   <= {w_tag, w_idx, {OFS_W{1'b0}}};
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            r_word_cnt <= r_word_cnt + OFS_W'(1);
            if (r_word_cnt == '1) begin
              r_mem_rd_req <= 1'b0;
              r_mem_addr   <= '0;
              r_state      <= DONE;
            end else begin
              r_mem_addr <= {r_miss_tag, r_miss_idx, r_word_cnt + OFS_W'(1)};
            end
          end
        end
        DONE: begin
          r_flush_pend <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetch_ready = w_hit;
  assign fetch_instr = (r_state == IDLE) ? r_data[{w_idx, w_ofs}] : '0;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_addr    = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 16'hFFFF)) r_hit_count <= r_hit_count + 16'd1;
      if (w_miss && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: expected refill addresses and
// instruction words are queued when a fetch is driven and checked as the DUT responds.
module tb_icache_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fetch_addr = 8'h00;
  logic [15:0] fetch_instr;
  logic        fetch_ready;
  logic        flush = 1'b0;
  logic        mem_rd_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int totalChecks = 0;
  int badChecks = 0;
  int waitCnt = 0;
  int cycles = 0;
  logic [31:0] wantAddr;
  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];

  always #5 clk = ~clk;

  icache_fetch_responder dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, observed, expected);
    end
  endtask

  // Off-chip memory: acks every held request two cycles later with 0x1000+addr.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst || !mem_rd_req) begin
        waitCnt = 0;
      end else begin
        waitCnt++;
        if (waitCnt == 2) begin
          if (expAddrQ.size() > 0) wantAddr = expAddrQ.pop_front();
          else wantAddr = 32'hFFFF_FFFF;
          checkOutput("memAddr", {24'd0, mem_addr}, wantAddr);
          mem_rdata = 16'h1000 + {8'd0, mem_addr};
          mem_ack = 1'b1;
          waitCnt = 0;
        end
      end
    end
  end

  task automatic waitReady(input int startCycles, output int nCycles);
    nCycles = startCycles;
    do begin
      @(negedge clk);
      nCycles++;
    end while (fetch_ready !== 1'b1 && nCycles < 200);
    checkOutput("readyTimeout", 32'(fetch_ready), 32'd1);
  endtask

  task automatic pushLine(input logic [7:0] addr);
    for (int w = 0; w < 4; w++) expAddrQ.push_back({24'd0, addr[7:2], 2'(w)});
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input bit isMiss, input int expCycles);
    int n;
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    fetch_addr = addr;
    expInstrQ.push_back(32'h1000 + {24'd0, addr});
    if (isMiss) begin
      pushLine(addr);
      #1;
      checkOutput("missReadyLow", 32'(fetch_ready), 32'd0);
      waitReady(0, n);
      checkOutput("missLatency", n, expCycles);
      checkOutput("lineDone", expAddrQ.size(), 32'd0);
    end else begin
      #1;
      checkOutput("hitReady", 32'(fetch_ready), 32'd1);
      checkOutput("noReqOnHit", 32'(mem_rd_req), 32'd0);
    end
    checkOutput("instr", {16'd0, fetch_instr}, expInstrQ.pop_front());
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReq", 32'(mem_rd_req), 32'd0);
    checkOutput("rstReady", 32'(fetch_ready), 32'd0);
    checkOutput("rstAddr", {24'd0, mem_addr}, 32'd0);
`ifdef ICACHE_STATS_EN
    checkOutput("rstHits", {16'd0, hit_count}, 32'd0);
    checkOutput("rstMisses", {16'd0, miss_count}, 32'd0);
`endif

    // Cold miss and sequential hits on the filled line.
    applyStimulus(8'h00, 1'b1, 10);
    applyStimulus(8'h01, 1'b0, 0);
    applyStimulus(8'h02, 1'b0, 0);
    applyStimulus(8'h03, 1'b0, 0);
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    checkOutput("hitCount", {16'd0, hit_count}, 32'd4);
    checkOutput("missCount", {16'd0, miss_count}, 32'd1);
`endif

    // Conflict on index 0 evicts and refills.
    applyStimulus(8'h20, 1'b1, 10);
    applyStimulus(8'h22, 1'b0, 0);
    applyStimulus(8'h00, 1'b1, 10);

    // Flush during the second refill word: line completes, then re-misses.
    @(negedge clk);
    rst = 1'b1;
    fetch_addr = 8'h44;
    pushLine(8'h44);
    pushLine(8'h44);
    #1;
    checkOutput("flushMissLow", 32'(fetch_ready), 32'd0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    waitReady(4, cycles);
    checkOutput("flushLatency", cycles, 32'd20);
    checkOutput("flushQueue", expAddrQ.size(), 32'd0);
    checkOutput("flushInstr", {16'd0, fetch_instr}, 32'h1044);

    // Flush pulse in IDLE suppresses the hit and forces a re-miss.
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flushIdleReady", 32'(fetch_ready), 32'd0);
    applyStimulus(8'h45, 1'b1, 10);

    // Reset in the middle of a refill abandons it and clears valid bits.
    @(negedge clk);
    fetch_addr = 8'h88;
    pushLine(8'h88);
    repeat (3) @(negedge clk);
    checkOutput("reqMidRefill", 32'(mem_rd_req), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMidReq", 32'(mem_rd_req), 32'd0);
    checkOutput("rstMidReady", 32'(fetch_ready), 32'd0);
    expAddrQ.delete();
    applyStimulus(8'h00, 1'b1, 10);
    applyStimulus(8'h03, 1'b0, 0);

`ifdef ICACHE_STATS_EN
    repeat (70000) @(negedge clk);
    checkOutput("hitSaturate", {16'd0, hit_count}, 32'h0000FFFF);
    checkOutput("missAfterRst", {16'd0, miss_count}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
